// File: rtl/fg_sram_arbiter_pkg.sv
// Shared definitions for the foreground SRAM arbiter: frame defaults,
// the queued write-entry layout and the pixel address mapping.
package fg_sram_arbiter_pkg;

  localparam int unsigned FG_PIXEL_SIZE   = 16;
  localparam int unsigned FG_RESOLUTION_X = 800;
  localparam int unsigned FG_RESOLUTION_Y = 600;
  localparam int unsigned FG_ADDR_WIDTH   = 19;

  typedef struct packed {
    logic [FG_ADDR_WIDTH-1:0] addr;
    logic [FG_PIXEL_SIZE-1:0] pixel;
  } fg_wr_entry_t;

  // Row-major word address; callers truncate to the SRAM address width.
  function automatic logic [31:0] fg_map_addr(input logic [31:0] x,
                                              input logic [31:0] y,
                                              input logic [31:0] res_x);
    fg_map_addr = y * res_x + x;
  endfunction

endpackage

// File: rtl/fg_sram_arbiter_pixel_write_fifo.sv
// Synchronous FIFO holding pending pixel writes; a pop in the same cycle
// frees a slot so a push into a full FIFO is still accepted.
module pixel_write_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Status flags and qualified push/pop strobes
  always_comb begin
    o_empty   = (r_wr_ptr == r_rd_ptr);
    o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_do_pop  = i_pop && !o_empty;
    w_do_push = i_push && (!o_full || w_do_pop);
    o_data    = r_mem[r_rd_ptr[AW-1:0]];
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_rst) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // Read and write pointers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fg_sram_arbiter.sv
// Foreground SRAM port arbiter: fixed-latency pipeline reads with absolute
// priority, SPI/capture pixel writes queued and issued on an idle bus.
module fg_sram_arbiter
  import fg_sram_arbiter_pkg::*;
#(
  parameter int PRECISION                    = 11,
  parameter int PIXEL_SIZE                   = FG_PIXEL_SIZE,
  parameter int RESOLUTION_X                 = FG_RESOLUTION_X,
  parameter int RESOLUTION_Y                 = FG_RESOLUTION_Y,
  parameter int ADDR_WIDTH                   = FG_ADDR_WIDTH,
  parameter int FOREGROUND_FETCH_CYCLE_DELAY = 5,
  parameter int SRAM_READ_LATENCY            = 2,
  parameter int WRITE_FIFO_DEPTH             = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic signed [PRECISION:0] i_fg_pixel_request_x,
  input  logic signed [PRECISION:0] i_fg_pixel_request_y,
  input  logic                    i_fg_pixel_request_active,
  output logic [PIXEL_SIZE-1:0]   o_fg_pixel_in,
  output logic                    o_fg_pixel_ready,
  input  logic [PRECISION-1:0]    i_ctrl_image_pixel_x,
  input  logic [PRECISION-1:0]    i_ctrl_image_pixel_y,
  input  logic [PIXEL_SIZE-1:0]   i_ctrl_image_pixel,
  input  logic                    i_ctrl_image_pixel_ready,
  input  logic [PRECISION-1:0]    i_cap_pixel_x,
  input  logic [PRECISION-1:0]    i_cap_pixel_y,
  input  logic [PIXEL_SIZE-1:0]   i_cap_pixel,
  input  logic                    i_cap_pixel_ready,
  input  logic                    i_ctrl_fg_freeze,
  output logic [ADDR_WIDTH-1:0]   o_sram_addr,
  output logic [PIXEL_SIZE-1:0]   o_sram_data_out,
  input  logic [PIXEL_SIZE-1:0]   i_sram_data_in,
  output logic                    o_sram_data_oe,
  output logic                    o_sram_we_n,
  output logic                    o_sram_oe_n,
  output logic                    o_write_overflow
);

  localparam int FD        = FOREGROUND_FETCH_CYCLE_DELAY;
  localparam int CAP_STAGE = SRAM_READ_LATENCY + 2;
  localparam int BUSY_W    = $clog2(SRAM_READ_LATENCY + 2);
  localparam int ENTRY_W   = $bits(fg_wr_entry_t);

  logic                  w_rd_valid;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_cap_live;
  logic                  w_spi_ok;
  logic                  w_cap_ok;
  logic                  w_collision;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_drop;
  fg_wr_entry_t          w_push_entry;
  fg_wr_entry_t          w_head;
  logic                  w_full;
  logic                  w_empty;

  logic                  r_rd_vld  [1:FD];
  logic [PIXEL_SIZE-1:0] r_rd_data [CAP_STAGE:FD];
  logic [BUSY_W-1:0]     r_busy_cnt;
  logic [ADDR_WIDTH-1:0] r_sram_addr;
  logic [PIXEL_SIZE-1:0] r_sram_data_out;
  logic                  r_sram_data_oe;
  logic                  r_sram_we_n;
  logic                  r_sram_oe_n;
  logic                  r_write_overflow;

  // Read-slot qualification and address
  always_comb begin
    w_rd_valid = i_fg_pixel_request_active &&
                 !i_fg_pixel_request_x[PRECISION] && !i_fg_pixel_request_y[PRECISION] &&
                 (32'(i_fg_pixel_request_x[PRECISION-1:0]) < 32'(RESOLUTION_X)) &&
                 (32'(i_fg_pixel_request_y[PRECISION-1:0]) < 32'(RESOLUTION_Y));
    w_rd_addr  = ADDR_WIDTH'(fg_map_addr(32'(i_fg_pixel_request_x[PRECISION-1:0]),
                                         32'(i_fg_pixel_request_y[PRECISION-1:0]),
                                         32'(RESOLUTION_X)));
  end

  // Write-source selection: SPI beats capture, a live capture collision is a drop
  always_comb begin
    w_cap_live  = i_cap_pixel_ready && !i_ctrl_fg_freeze;
    w_spi_ok    = i_ctrl_image_pixel_ready &&
                  (32'(i_ctrl_image_pixel_x) < 32'(RESOLUTION_X)) &&
                  (32'(i_ctrl_image_pixel_y) < 32'(RESOLUTION_Y));
    w_cap_ok    = w_cap_live &&
                  (32'(i_cap_pixel_x) < 32'(RESOLUTION_X)) &&
                  (32'(i_cap_pixel_y) < 32'(RESOLUTION_Y));
    w_collision = i_ctrl_image_pixel_ready && w_cap_live;
    w_push      = w_spi_ok || (w_cap_ok && !i_ctrl_image_pixel_ready);
    if (i_ctrl_image_pixel_ready) begin
      w_push_entry.addr  = ADDR_WIDTH'(fg_map_addr(32'(i_ctrl_image_pixel_x),
                                                   32'(i_ctrl_image_pixel_y),
                                                   32'(RESOLUTION_X)));
      w_push_entry.pixel = i_ctrl_image_pixel;
    end else begin
      w_push_entry.addr  = ADDR_WIDTH'(fg_map_addr(32'(i_cap_pixel_x),
                                                   32'(i_cap_pixel_y),
                                                   32'(RESOLUTION_X)));
      w_push_entry.pixel = i_cap_pixel;
    end
    // A write may only drive the bus once read data has fully cleared it
    w_issue = !w_empty && !w_rd_valid && (r_busy_cnt == {BUSY_W{1'b0}});
    w_drop  = w_collision || (w_push && w_full && !w_issue);
  end

  pixel_write_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (WRITE_FIFO_DEPTH)
  ) u_write_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_issue),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // SRAM pin registers, bus-idle counter and overflow flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sram_addr      <= {ADDR_WIDTH{1'b0}};
      r_sram_data_out  <= {PIXEL_SIZE{1'b0}};
      r_sram_data_oe   <= 1'b0;
      r_sram_we_n      <= 1'b1;
      r_sram_oe_n      <= 1'b1;
      r_busy_cnt       <= {BUSY_W{1'b0}};
      r_write_overflow <= 1'b0;
    end else begin
      r_sram_oe_n    <= !w_rd_valid;
      r_sram_we_n    <= !w_issue;
      r_sram_data_oe <= w_issue;
      if (w_rd_valid) begin
        r_sram_addr <= w_rd_addr;
      end else if (w_issue) begin
        r_sram_addr <= w_head.addr;
      end
      if (w_issue) begin
        r_sram_data_out <= w_head.pixel;
      end
      if (w_rd_valid) begin
        r_busy_cnt <= BUSY_W'(SRAM_READ_LATENCY + 1);
      end else if (r_busy_cnt != {BUSY_W{1'b0}}) begin
        r_busy_cnt <= r_busy_cnt - BUSY_W'(1);
      end
      if (w_drop) begin
        r_write_overflow <= 1'b1;
      end
    end
  end

  // Read valid delay line; data is captured once it is on the SRAM pins
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 1; s <= FD; s++) begin
        r_rd_vld[s] <= 1'b0;
      end
      for (int s = CAP_STAGE; s <= FD; s++) begin
        r_rd_data[s] <= {PIXEL_SIZE{1'b0}};
      end
    end else begin
      r_rd_vld[1] <= w_rd_valid;
      for (int s = 2; s <= FD; s++) begin
        r_rd_vld[s] <= r_rd_vld[s-1];
      end
      r_rd_data[CAP_STAGE] <= r_rd_vld[CAP_STAGE-1] ? i_sram_data_in : {PIXEL_SIZE{1'b0}};
      for (int s = CAP_STAGE + 1; s <= FD; s++) begin
        r_rd_data[s] <= r_rd_data[s-1];
      end
    end
  end

  assign o_fg_pixel_ready = r_rd_vld[FD];
  assign o_fg_pixel_in    = r_rd_data[FD];
  assign o_sram_addr      = r_sram_addr;
  assign o_sram_data_out  = r_sram_data_out;
  assign o_sram_data_oe   = r_sram_data_oe;
  assign o_sram_we_n      = r_sram_we_n;
  assign o_sram_oe_n      = r_sram_oe_n;
  assign o_write_overflow = r_write_overflow;

endmodule

// File: tb/tb_fg_sram_arbiter.sv
// Directed self-checking bench for fg_sram_arbiter; inputs change #1 after
// the rising edge and outputs are checked in that same window.
module tb_fg_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] req_x, req_y;
  logic        req_act;
  logic [15:0] pix_in;
  logic        pix_rdy;
  logic [10:0] spi_x, spi_y, cap_x, cap_y;
  logic [15:0] spi_pix, cap_pix;
  logic        spi_rdy, cap_rdy, freeze;
  logic [18:0] sram_addr;
  logic [15:0] sram_dout, sram_din;
  logic        sram_doe, we_n, oe_n, ovf;

  int checks = 0;
  int errors = 0;
  int got_n = 0;
  logic [18:0] got_addr [32];
  logic [15:0] got_data [32];
  logic        got_doe  [32];

  always #5 clk = ~clk;

  fg_sram_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_fg_pixel_request_x(req_x), .i_fg_pixel_request_y(req_y),
    .i_fg_pixel_request_active(req_act),
    .o_fg_pixel_in(pix_in), .o_fg_pixel_ready(pix_rdy),
    .i_ctrl_image_pixel_x(spi_x), .i_ctrl_image_pixel_y(spi_y),
    .i_ctrl_image_pixel(spi_pix), .i_ctrl_image_pixel_ready(spi_rdy),
    .i_cap_pixel_x(cap_x), .i_cap_pixel_y(cap_y),
    .i_cap_pixel(cap_pix), .i_cap_pixel_ready(cap_rdy),
    .i_ctrl_fg_freeze(freeze),
    .o_sram_addr(sram_addr), .o_sram_data_out(sram_dout),
    .i_sram_data_in(sram_din), .o_sram_data_oe(sram_doe),
    .o_sram_we_n(we_n), .o_sram_oe_n(oe_n), .o_write_overflow(ovf)
  );

  // Write-pulse monitor sampled on the falling edge
  always @(negedge clk) begin
    if (we_n === 1'b0 && got_n < 32) begin
      got_addr[got_n] = sram_addr;
      got_data[got_n] = sram_dout;
      got_doe[got_n]  = sram_doe;
      got_n = got_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_x = 12'd0; req_y = 12'd0; req_act = 1'b0;
    spi_x = 11'd0; spi_y = 11'd0; spi_pix = 16'd0; spi_rdy = 1'b0;
    cap_x = 11'd0; cap_y = 11'd0; cap_pix = 16'd0; cap_rdy = 1'b0;
    freeze = 1'b0; sram_din = 16'd0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(pix_rdy), 32'd0);
    chk({tag, "_pixel"}, 32'(pix_in), 32'd0);
    chk({tag, "_addr"}, 32'(sram_addr), 32'd0);
    chk({tag, "_dout"}, 32'(sram_dout), 32'd0);
    chk({tag, "_doe"}, 32'(sram_doe), 32'd0);
    chk({tag, "_we_n"}, 32'(we_n), 32'd1);
    chk({tag, "_oe_n"}, 32'(oe_n), 32'd1);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    step(); step();
    check_reset_values("rst0");
    rst = 1'b0;
    step(); step();

    // Read (3,2): address 2*800+3 = 1603, data returned in cycle 5
    req_x = 12'd3; req_y = 12'd2; req_act = 1'b1;     // cycle 0
    step(); req_act = 1'b0;                            // cycle 1
    chk("rd_addr", 32'(sram_addr), 32'd1603);
    chk("rd_oe_n_c1", 32'(oe_n), 32'd0);
    step();                                            // cycle 2
    chk("rd_oe_n_c2", 32'(oe_n), 32'd1);
    step(); sram_din = 16'hBEEF;                       // cycle 3
    step(); sram_din = 16'h0000;                       // cycle 4
    chk("rd_ready_c4", 32'(pix_rdy), 32'd0);
    step();                                            // cycle 5
    chk("rd_ready_c5", 32'(pix_rdy), 32'd1);
    chk("rd_pixel_c5", 32'(pix_in), 32'hBEEF);
    step();                                            // cycle 6
    chk("rd_ready_c6", 32'(pix_rdy), 32'd0);
    step(); step();

    // Invalid reads (-1,0) then (800,0): no SRAM access, no ready
    sram_din = 16'h1234;
    req_x = 12'hFFF; req_y = 12'd0; req_act = 1'b1;   // cycle 0
    step();                                            // cycle 1
    req_x = 12'd800;
    chk("inv_oe_n_c1", 32'(oe_n), 32'd1);
    step(); req_act = 1'b0;                            // cycle 2
    chk("inv_oe_n_c2", 32'(oe_n), 32'd1);
    step(); step(); step();                            // cycle 5
    chk("inv_ready_c5", 32'(pix_rdy), 32'd0);
    chk("inv_pixel_c5", 32'(pix_in), 32'd0);
    step();                                            // cycle 6
    chk("inv_ready_c6", 32'(pix_rdy), 32'd0);
    chk("inv_pixel_c6", 32'(pix_in), 32'd0);
    sram_din = 16'h0000;
    step(); step(); step();

    // Read issues on the bus in cycles 1..10; SPI write to (0,1) strobed in cycle 1
    for (int c = 0; c < 14; c++) begin
      req_act = (c <= 9);
      req_x = 12'(c); req_y = 12'd0;
      spi_rdy = (c == 1); spi_x = 11'd0; spi_y = 11'd1; spi_pix = 16'hABCD;
      chk($sformatf("busy_we_n_c%0d", c), 32'(we_n), 32'd1);
      step();
    end
    clear_inputs();                                    // cycle 14
    chk("wr_we_n_c14", 32'(we_n), 32'd0);
    chk("wr_addr_c14", 32'(sram_addr), 32'd800);
    chk("wr_dout_c14", 32'(sram_dout), 32'hABCD);
    chk("wr_doe_c14", 32'(sram_doe), 32'd1);
    step();                                            // cycle 15
    chk("wr_we_n_c15", 32'(we_n), 32'd1);
    chk("wr_doe_c15", 32'(sram_doe), 32'd0);
    step(); step();

    // Nine SPI writes under continuous reads: eight queued, one overflow
    got_n = 0;
    for (int c = 0; c < 12; c++) begin
      req_act = 1'b1; req_x = 12'(c); req_y = 12'd0;
      spi_rdy = (c >= 1 && c <= 9);
      spi_x = 11'(c - 1); spi_y = 11'd0; spi_pix = 16'h1000 + 16'(c - 1);
      if (c == 9) chk("ovf_before_9th", 32'(ovf), 32'd0);
      if (c == 10) chk("ovf_after_9th", 32'(ovf), 32'd1);
      step();
    end
    clear_inputs();
    chk("fifo_no_write_during_reads", 32'(got_n), 32'd0);
    for (int i = 0; i < 20; i++) step();
    chk("fifo_pulse_count", 32'(got_n), 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("fifo_addr_%0d", k), 32'(got_addr[k]), 32'(k));
      chk($sformatf("fifo_data_%0d", k), 32'(got_data[k]), 32'h1000 + 32'(k));
      chk($sformatf("fifo_doe_%0d", k), 32'(got_doe[k]), 32'd1);
    end

    // Freeze, collision, lone capture and an out-of-range SPI write
    rst = 1'b1; step(); rst = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'd0);
    got_n = 0;
    cap_rdy = 1'b1; freeze = 1'b1; cap_x = 11'd6; cap_y = 11'd6; cap_pix = 16'h2222;
    step();
    chk("ovf_freeze", 32'(ovf), 32'd0);
    freeze = 1'b0;
    spi_rdy = 1'b1; spi_x = 11'd5; spi_y = 11'd5; spi_pix = 16'h1111;
    step();
    chk("ovf_collision", 32'(ovf), 32'd1);
    spi_rdy = 1'b0;
    cap_x = 11'd1; cap_y = 11'd0; cap_pix = 16'h4444;
    step();
    cap_rdy = 1'b0;
    spi_rdy = 1'b1; spi_x = 11'd800; spi_y = 11'd0; spi_pix = 16'h7777;
    step();
    clear_inputs();
    for (int i = 0; i < 10; i++) step();
    chk("mix_pulse_count", 32'(got_n), 32'd2);
    chk("mix_addr_0", 32'(got_addr[0]), 32'd4005);
    chk("mix_data_0", 32'(got_data[0]), 32'h1111);
    chk("mix_addr_1", 32'(got_addr[1]), 32'd1);
    chk("mix_data_1", 32'(got_data[1]), 32'h4444);
    chk("mix_ovf_sticky", 32'(ovf), 32'd1);

    // Reset in cycle 3 after a read in cycle 0 and a queued write
    got_n = 0;
    req_x = 12'd3; req_y = 12'd2; req_act = 1'b1;     // cycle 0
    spi_rdy = 1'b1; spi_x = 11'd9; spi_y = 11'd0; spi_pix = 16'h5555;
    step(); clear_inputs();                            // cycle 1
    step();                                            // cycle 2
    step(); rst = 1'b1; sram_din = 16'hBEEF;           // cycle 3
    step(); rst = 1'b0; sram_din = 16'h0000;           // cycle 4
    check_reset_values("midrst");
    step();                                            // cycle 5
    chk("midrst_ready_c5", 32'(pix_rdy), 32'd0);
    chk("midrst_pixel_c5", 32'(pix_in), 32'd0);
    for (int i = 0; i < 6; i++) step();
    chk("midrst_no_write", 32'(got_n), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
